// File: rtl/alu_seq_pkg.sv
// Shared types for the handshaked sequential ALU: opcodes, FSM states and the flag vector.
package alu_seq_pkg;

  localparam int FLAG_W = 4;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_MUL = 3'b110,
    OP_SRA = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier iterator: one partial product per clock, WIDTH iterations per start.
// done/product are combinational so the caller can register the final sum on the last edge.
module alu_mul_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  logic                 run_p1;
  logic [CNT_W-1:0]     cnt_p1;
  logic [2*WIDTH-1:0]   mcand_p1;
  logic [WIDTH-1:0]     mplier_p1;
  logic [2*WIDTH-1:0]   acc_p1;
  logic [2*WIDTH-1:0]   acc_nxt;

  assign acc_nxt = acc_p1 + (mplier_p1[0] ? mcand_p1 : '0);
  assign done    = run_p1 && (cnt_p1 == CNT_W'(WIDTH - 1));
  assign product = acc_nxt;

  // stage p1: iteration control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_p1 <= 1'b0;
      cnt_p1 <= '0;
    end else if (start) begin
      run_p1 <= 1'b1;
      cnt_p1 <= '0;
    end else if (run_p1) begin
      if (done) begin
        run_p1 <= 1'b0;
      end
      cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

  // stage p1: shift-add datapath
  always_ff @(posedge clk) begin
    if (start) begin
      mcand_p1  <= {{WIDTH{1'b0}}, a};
      mplier_p1 <= b;
      acc_p1    <= '0;
    end else if (run_p1) begin
      acc_p1    <= acc_nxt;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result/flags and a multi-cycle shift-add MUL.
// Build option ALU_SEQ_MUL_EN: when undefined, opcode 110 is flagged illegal (C=V=1) in one cycle.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [2:0]        ALUControl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  ALUResult,
  output logic [FLAG_W-1:0] flags,
  output logic              busy
);

  localparam int SH_W = CNT_W - 1;

  alu_state_e  state, state_d;
  alu_op_e     op;
  logic        accept;
  logic        load;
  logic        c_d, v_d;
  logic [WIDTH-1:0] res_d;
  alu_flags_t  flags_q, flags_d;

  logic [WIDTH:0]   add_p0;
  logic [WIDTH:0]   sub_p0;
  logic             add_v_p0;
  logic             sub_v_p0;
  logic [WIDTH-1:0] sra_p0;

  assign op       = alu_op_e'(ALUControl);
  assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  // stage p0: single-cycle arithmetic on the live operands
  assign add_p0   = {1'b0, a} + {1'b0, b};
  assign sub_p0   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign add_v_p0 = (a[WIDTH-1] == b[WIDTH-1]) && (add_p0[WIDTH-1] != a[WIDTH-1]);
  assign sub_v_p0 = (a[WIDTH-1] != b[WIDTH-1]) && (sub_p0[WIDTH-1] != a[WIDTH-1]);
  assign sra_p0   = $signed(a) >>> b[SH_W-1:0];

`ifdef ALU_SEQ_MUL_EN
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign mul_start = accept && (op == OP_MUL);

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign busy = (state == MUL);
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_d = state;
    load    = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
          if (op == OP_MUL) begin
            state_d = MUL;
          end else begin
            state_d = HOLD;
            load    = 1'b1;
          end
`else
          state_d = HOLD;
          load    = 1'b1;
`endif
        end else if ((state == HOLD) && out_ready) begin
          state_d = IDLE;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        if (mul_done) begin
          state_d = HOLD;
          load    = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // SLT reuses the subtractor: a<b (signed) exactly when N^V of a-b
  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    if (state == MUL) begin
      res_d = mul_prod[WIDTH-1:0];
      c_d   = |mul_prod[2*WIDTH-1:WIDTH];
    end else begin
`else
    begin
`endif
      case (op)
        OP_AND: res_d = a & b;
        OP_OR:  res_d = a | b;
        OP_ADD: begin
          res_d = add_p0[WIDTH-1:0];
          c_d   = add_p0[WIDTH];
          v_d   = add_v_p0;
        end
        OP_SUB: begin
          res_d = sub_p0[WIDTH-1:0];
          c_d   = sub_p0[WIDTH];
          v_d   = sub_v_p0;
        end
        OP_XOR: res_d = a ^ b;
        OP_SLT: res_d = {{(WIDTH-1){1'b0}}, sub_p0[WIDTH-1] ^ sub_v_p0};
        OP_MUL: begin
`ifndef ALU_SEQ_MUL_EN
          c_d = 1'b1;
          v_d = 1'b1;
`endif
        end
        OP_SRA: res_d = sra_p0;
        default: res_d = '0;
      endcase
    end
  end

  always_comb begin
    flags_d   = '0;
    flags_d.n = res_d[WIDTH-1];
    flags_d.z = (res_d == '0);
    flags_d.c = c_d;
    flags_d.v = v_d;
  end

  // stage p1: FSM state and registered result/flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ALUResult <= '0;
      flags_q   <= '0;
    end else begin
      state <= state_d;
      if (load) begin
        ALUResult <= res_d;
        flags_q   <= flags_d;
      end
    end
  end

  assign out_valid = (state == HOLD);
  assign flags     = flags_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 8-bit 2-op combinational ALU.
- WIDTH-bit operands, 3-bit ALUControl (8 ops), registered result, status flags.
- Multiplier runs multi-cycle as a shift-add sequence.
- Sits between the register-file read stage and writeback; valid/ready on both sides.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and op present
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ALUControl  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 SLT (signed), 110 MUL (low half), 111 SRA (a >>> b[$clog2(WIDTH)-1:0])
- out_valid  output  1  ALUResult/flags valid
- out_ready  input  1  consumer takes result
- ALUResult  output  WIDTH  registered result
- flags  output  4  {N, Z, C, V}
- busy  output  1  high while in MUL state

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, out_valid=0, ALUResult=0, flags=0, busy=0.
- No transfer occurs while rst_n is low.
- States:
  - IDLE: no result held.
  - MUL: iterating.
  - HOLD: result held and out_valid=1.
- in_ready is combinational: 1 in IDLE, or in HOLD when out_ready=1. It is 0 in MUL, and 0 in HOLD when out_ready=0.
- Accept: a transfer occurs when in_valid && in_ready at the rising edge.
- Single-cycle ops (all except MUL):
  - Result and flags are registered at the accept edge. State becomes HOLD; out_valid=1 in the following cycle.
  - Latency is 1. Throughput is 1 per cycle when out_ready stays 1 (HOLD->HOLD with a new result).
- MUL:
  - Operands are latched at the accept edge; state becomes MUL, count=0, acc=0.
  - Each edge: if mplier[0], acc += mcand (2*WIDTH-bit acc). Then mcand <<= 1, mplier >>= 1, count++.
  - After WIDTH iterations, ALUResult = acc[WIDTH-1:0], state HOLD, out_valid=1.
  - Latency is WIDTH cycles after the accept edge. Operand bits are treated as unsigned; the low half is sign-agnostic.
- HOLD with out_ready=0: ALUResult, flags and out_valid are held stable; no new accept.
- HOLD with out_ready=1 and no accepted input: next state IDLE, out_valid=0. ALUResult keeps its last value.
- Flags:
  - Z = (ALUResult==0).
  - N = ALUResult[WIDTH-1].
  - ADD: C = carry out; V = signed overflow.
  - SUB: computed as a + ~b + 1. C = carry out (1 means no borrow, a>=b unsigned); V = signed overflow.
  - MUL: C = |acc[2W-1:W] (unsigned overflow); V = 0.
  - AND/OR/XOR/SLT/SRA: C = 0, V = 0.
  - SLT result is 1 if $signed(a) < $signed(b), else 0. Compute it from the sub result as N^V, not via a separate comparator.
- Reset mid-operation: an in-flight MUL or held result is discarded; out_valid drops asynchronously.
- Shift amounts >= WIDTH cannot occur; only the low $clog2(WIDTH) bits of b are used.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: MUL behaves as above; MUL state and multiplier sub-module are present.
- Undefined: opcode 110 completes as a single-cycle op with ALUResult=0 and flags={N=0,Z=1,C=1,V=1}. The {C,V}=11 pair marks an illegal op. MUL state, counter and busy logic are removed, and busy is tied 0.

Decomposition:
- Package alu_seq_pkg holds:
  - enum alu_op_e (3-bit opcodes above)
  - enum alu_state_e {IDLE, MUL, HOLD}
  - packed struct alu_flags_t {n, z, c, v}
  - localparam FLAG_W = 4
- Sub-module alu_mul_seq (shift-add iterator):
  - start, a, b in; done, product[2W-1:0] out.
  - Instantiated only under ALU_SEQ_MUL_EN.

Test Plan (WIDTH=8, out_ready=1 unless stated):
- Reset: hold rst_n=0 for 3 cycles with in_valid=1, ALUControl=010 -> out_valid=0, ALUResult=0x00, flags=0. After release, in_ready=1.
- ADD 0x7F+0x01 -> next cycle ALUResult=0x80, N=1, Z=0, C=0, V=1. ADD 0xFF+0x01 -> 0x00, Z=1, C=1, V=0.
- SUB 0x02-0x02 -> 0x00, Z=1, C=1. SUB 0x01-0x02 -> 0xFF, N=1, C=0. SLT a=0x80, b=0x01 -> 0x01.
- MUL 0x10*0x11 -> in_ready=0 and busy=1 for 8 cycles. Then out_valid=1, ALUResult=0x10, C=1 (full product 0x0110). Undefined macro -> 0x00, flags=0111.
- Backpressure: AND 0xF0&0x3C with out_ready=0 for 5 cycles -> ALUResult=0x30 stable, in_ready=0. Raise out_ready together with OR 0x0F|0xA0 -> next cycle 0xAF, no bubble.
- Reset mid-MUL: assert rst_n=0 on the 3rd iteration cycle -> out_valid never asserts, state IDLE. A following ADD 0x01+0x01 returns 0x02.
